// File: rtl/differential_decoder_if.sv
// differential_decoder_if: byte stream in, decoded byte stream out, accepted-byte count
interface differential_decoder_if;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_in;
    logic        resync;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_out;
    logic [15:0] byte_count;

    modport master (
        output data_in, valid_in, resync, ready_out,
        input  ready_in, data_out, valid_out, byte_count
    );

    modport slave (
        input  data_in, valid_in, resync, ready_out,
        output ready_in, data_out, valid_out, byte_count
    );
endinterface

// File: rtl/differential_decoder.sv
// differential_decoder: recovers d[n] = e[n] ^ e[n-1] into a 2-entry output buffer
module differential_decoder #(
    parameter logic [7:0] SEED  = 8'h00,
    parameter int         DEPTH = 2
) (
    input logic clk,
    input logic rst,
    differential_decoder_if.slave bus
);
    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [7:0]  prev_q, prev_d;
    logic [7:0]  mem_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] bc_q, bc_d;
    logic [7:0]  chain;
    logic        push, pop;

    // Handshakes depend only on registered count, so no ready_out -> ready_in path
    always_comb begin
        chain    = bus.resync ? SEED : prev_q;
        push     = bus.valid_in && (cnt_q != FULL);
        pop      = (cnt_q != 2'd0) && bus.ready_out;
        prev_d   = push ? bus.data_in : (bus.resync ? SEED : prev_q);
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
        bc_d     = push ? bc_q + 16'd1 : bc_q;
    end

    // Chain, pointers, occupancy and accepted-byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= SEED;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            bc_q     <= 16'd0;
        end else begin
            prev_q   <= prev_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            bc_q     <= bc_d;
        end
    end

    // Buffer storage, cleared on reset so data_out reads 00 while empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= 8'h00;
            mem_q[1] <= 8'h00;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in ^ chain;
        end
    end

    assign bus.ready_in   = (cnt_q != FULL);
    assign bus.valid_out  = (cnt_q != 2'd0);
    assign bus.data_out   = mem_q[rd_ptr_q];
    assign bus.byte_count = bc_q;
endmodule

// File: tb/tb_differential_decoder.sv
// tb_differential_decoder: directed vector table plus reset, random-stream and wrap sequences
module tb_differential_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    differential_decoder_if bus();

    differential_decoder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vin;
        logic [7:0]  din;
        logic        rsy;
        logic        rout;
        logic        vout;
        logic [7:0]  dout;
        logic        rin;
        logic [15:0] bc;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mprev;
        logic [7:0] din;
        int         bad;

        vecs[0]  = '{1'b1, 8'h5B, 1'b0, 1'b1, 1'b1, 8'h5B, 1'b1, 16'd1};
        vecs[1]  = '{1'b1, 8'h73, 1'b0, 1'b1, 1'b1, 8'h28, 1'b1, 16'd2};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd2};
        vecs[3]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h62, 1'b1, 16'd3};
        vecs[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h62, 1'b0, 16'd4};
        vecs[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h62, 1'b0, 16'd4};
        vecs[6]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 16'd4};
        vecs[7]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 16'd5};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd5};
        vecs[9]  = '{1'b1, 8'h5B, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b1, 16'd6};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd6};
        vecs[11] = '{1'b1, 8'h73, 1'b0, 1'b1, 1'b1, 8'h73, 1'b1, 16'd7};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd7};
        vecs[13] = '{1'b1, 8'h5B, 1'b0, 1'b1, 1'b1, 8'h28, 1'b1, 16'd8};
        vecs[14] = '{1'b1, 8'h73, 1'b1, 1'b1, 1'b1, 8'h73, 1'b1, 16'd9};
        vecs[15] = '{1'b1, 8'h73, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 16'd10};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd10};

        bus.data_in   = 8'h00;
        bus.valid_in  = 1'b0;
        bus.resync    = 1'b0;
        bus.ready_out = 1'b0;
        #12;
        chk("rst_valid_out", 16'(bus.valid_out), 16'd0);
        chk("rst_ready_in", 16'(bus.ready_in), 16'd1);
        chk("rst_byte_count", bus.byte_count, 16'd0);
        chk("rst_data_out", 16'(bus.data_out), 16'h00);
        rst = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            bus.valid_in  = vecs[i].vin;
            bus.data_in   = vecs[i].din;
            bus.resync    = vecs[i].rsy;
            bus.ready_out = vecs[i].rout;
            step();
            chk($sformatf("v%0d_valid_out", i), 16'(bus.valid_out), 16'(vecs[i].vout));
            chk($sformatf("v%0d_ready_in", i), 16'(bus.ready_in), 16'(vecs[i].rin));
            chk($sformatf("v%0d_byte_count", i), bus.byte_count, vecs[i].bc);
            if (vecs[i].vout) chk($sformatf("v%0d_data_out", i), 16'(bus.data_out), 16'(vecs[i].dout));
        end
        bus.resync = 1'b0;

        mprev = 8'h73;
        bus.ready_out = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            din = 8'($urandom);
            bus.valid_in = 1'b1;
            bus.data_in  = din;
            step();
            if (!(bus.valid_out && bus.ready_in && bus.data_out == (din ^ mprev))) begin
                bad++;
                $display("FAIL stream%0d: got %h expected %h", i, bus.data_out, din ^ mprev);
            end
            mprev = din;
        end
        chk("stream_errors", 16'(bad), 16'd0);
        chk("stream_byte_count", bus.byte_count, 16'd110);
        bus.valid_in = 1'b0;
        step();
        chk("stream_drained", 16'(bus.valid_out), 16'd0);

        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        bus.data_in   = 8'hC3;
        step();
        bus.data_in   = 8'h3C;
        step();
        bus.valid_in  = 1'b0;
        chk("midrst_full", 16'(bus.ready_in), 16'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid_out", 16'(bus.valid_out), 16'd0);
        chk("midrst_ready_in", 16'(bus.ready_in), 16'd1);
        chk("midrst_byte_count", bus.byte_count, 16'd0);
        chk("midrst_data_out", 16'(bus.data_out), 16'h00);
        #1 rst = 1'b0;
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.data_in   = 8'h5B;
        step();
        chk("postrst_seed", 16'(bus.data_out), 16'h5B);
        bus.valid_in = 1'b0;
        step();

        rst = 1'b1;
        #1 rst = 1'b0;
        mprev = 8'h00;
        bad = 0;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            din = 8'(i) ^ 8'hA5;
            bus.data_in = din;
            step();
            if (bus.data_out != (din ^ mprev) || !bus.valid_out) bad++;
            mprev = din;
            if (i == 65534) chk("wrap_ffff", bus.byte_count, 16'hFFFF);
        end
        chk("wrap_byte_count", bus.byte_count, 16'h0001);
        chk("wrap_chain_errors", 16'(bad), 16'd0);
        bus.valid_in = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
